// File: rtl/exp4_gravador_sequencia_if.sv
// rtl/exp4_gravador_sequencia_if.sv - sequence memory write port
//
// Purpose: carries one write per stored move from the recorder to the memory.
// Signals:
//   mem_we    write enable, one cycle per stored move
//   mem_addr  write address (move index)
//   mem_dado  write data (one-hot button code)
// Modports: master = recorder side (drives), slave = memory side (receives).

interface exp4_gravador_sequencia_if #(
    parameter int ADDR_W = 4
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_dado;

    modport master (output mem_we, output mem_addr, output mem_dado);
    modport slave  (input  mem_we, input  mem_addr, input  mem_dado);
endinterface

// File: rtl/exp4_gravador_sequencia.sv
// rtl/exp4_gravador_sequencia.sv - records one-hot button presses into the sequence memory
//
// Purpose: Moore FSM plus move counter and data register. It writes each valid
// one-hot press from the player into the sequence memory, one word per move.
// Ports:
//   clock, reset  clock; asynchronous active-high reset
//   iniciar       start recording (sampled in inicial)
//   finalizar     end recording early (sampled in espera, wins over a key)
//   chaves        player buttons, expected one-hot
//   mem           memory write port (mem_we / mem_addr / mem_dado)
//   tamanho       number of moves stored in the current/last recording
//   gravando      high while a recording is in progress
//   pronto        one-cycle pulse in fim
//   erro          one-cycle pulse in invalido
//   timeout       one-cycle pulse on idle timeout
//   db_estado     current state code
// Optional feature macro: GRAVADOR_TIMEOUT_EN (idle timeout in espera).

module exp4_gravador_sequencia #(
    parameter int N              = 16,
    parameter int ADDR_W         = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                iniciar,
    input  logic                                finalizar,
    input  logic [3:0]                          chaves,
    exp4_gravador_sequencia_if.master           mem,
    output logic [ADDR_W:0]                     tamanho,
    output logic                                gravando,
    output logic                                pronto,
    output logic                                erro,
    output logic                                timeout,
    output logic [3:0]                          db_estado
);

    if (N < 1 || N > (1 << ADDR_W) || TIMEOUT_CICLOS < 1) begin : g_param_check
        $error("exp4_gravador_sequencia: invalid N/ADDR_W/TIMEOUT_CICLOS");
    end

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        SOLTA      = 4'h3,
        REGISTRA   = 4'h4,
        GRAVA      = 4'h5,
        PROXIMO    = 4'h6,
        FIM        = 4'hD,
        INVALIDO   = 4'hE
    } estado_t;

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N - 1);

    estado_t           estado, proximo_estado;
    logic [ADDR_W-1:0] contador;
    logic [3:0]        registro;
    logic              chave_valida;
    logic              chave_invalida;
    logic              fim_por_timeout;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign chave_valida   = (chaves != 4'b0000) && ((chaves & (chaves - 4'b0001)) == 4'b0000);
    assign chave_invalida = (chaves != 4'b0000) && !chave_valida;

`ifdef GRAVADOR_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMITE = IDLE_W'(TIMEOUT_CICLOS - 1);

    logic [IDLE_W-1:0] ocioso;
    logic              expirou;
    logic              timeout_pend;

    // espera is only entered from solta, so clearing there restarts the count
    // on every entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ocioso <= '0;
        end else if (estado == ESPERA) begin
            ocioso <= ocioso + IDLE_W'(1);
        end else begin
            ocioso <= '0;
        end
    end

    assign expirou = (ocioso == IDLE_LIMITE);

    // Remembers that the coming invalido visit was caused by the timeout, so
    // timeout and erro pulse in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_pend <= 1'b0;
        end else begin
            timeout_pend <= fim_por_timeout;
        end
    end

    assign timeout = (estado == INVALIDO) && timeout_pend;
`else
    logic expirou;
    assign expirou = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado  = INICIAL;
        db_estado       = 4'hF;
        gravando        = 1'b0;
        mem.mem_we      = 1'b0;
        pronto          = 1'b0;
        erro            = 1'b0;
        fim_por_timeout = 1'b0;
        case (estado)
            INICIAL: begin
                db_estado      = 4'h0;
                proximo_estado = iniciar ? PREPARACAO : INICIAL;
            end
            PREPARACAO: begin
                db_estado      = 4'h1;
                gravando       = 1'b1;
                proximo_estado = SOLTA;
            end
            SOLTA: begin
                db_estado      = 4'h3;
                gravando       = 1'b1;
                proximo_estado = (chaves == 4'b0000) ? ESPERA : SOLTA;
            end
            ESPERA: begin
                db_estado = 4'h2;
                gravando  = 1'b1;
                if (finalizar) begin
                    proximo_estado = FIM;
                end else if (chave_valida) begin
                    proximo_estado = REGISTRA;
                end else if (chave_invalida) begin
                    proximo_estado = INVALIDO;
                end else if (expirou) begin
                    proximo_estado  = INVALIDO;
                    fim_por_timeout = 1'b1;
                end else begin
                    proximo_estado = ESPERA;
                end
            end
            REGISTRA: begin
                db_estado      = 4'h4;
                gravando       = 1'b1;
                proximo_estado = GRAVA;
            end
            GRAVA: begin
                db_estado      = 4'h5;
                gravando       = 1'b1;
                mem.mem_we     = 1'b1;
                proximo_estado = (contador == ULTIMO) ? FIM : PROXIMO;
            end
            PROXIMO: begin
                db_estado      = 4'h6;
                gravando       = 1'b1;
                proximo_estado = SOLTA;
            end
            FIM: begin
                db_estado      = 4'hD;
                pronto         = 1'b1;
                proximo_estado = INICIAL;
            end
            INVALIDO: begin
                db_estado      = 4'hE;
                erro           = 1'b1;
                proximo_estado = INICIAL;
            end
            default: begin
                db_estado      = 4'hF;
                proximo_estado = INICIAL;
            end
        endcase
    end

    // Datapath: counter, data register and stored-move count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            contador <= '0;
            registro <= 4'b0000;
            tamanho  <= '0;
        end else begin
            case (estado)
                PREPARACAO: begin
                    contador <= '0;
                    registro <= 4'b0000;
                    tamanho  <= '0;
                end
                REGISTRA: registro <= chaves;
                GRAVA:    tamanho  <= {1'b0, contador} + (ADDR_W + 1)'(1);
                PROXIMO:  contador <= contador + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    assign mem.mem_addr = contador;
    assign mem.mem_dado = registro;

endmodule

// File: doc/exp4_gravador_sequencia.md
Name: exp4_gravador_sequencia

Overview:
Write-side counterpart of the game's comparison control unit. It records a sequence of one-hot button presses from the player into the sequence memory, so the comparison unit can later read it back. Moore FSM plus an address counter and a data register; it drives the memory write port directly. db_estado uses the same state-code style as the comparison unit.

Parameters:
N, 16, maximum sequence length (number of memory words written)
ADDR_W, 4, memory address width; N <= 2**ADDR_W
TIMEOUT_CICLOS, 1000, idle cycles allowed in espera (used only with GRAVADOR_TIMEOUT_EN)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
iniciar  in  1  start recording (level, sampled in inicial)
finalizar  in  1  end recording early (sampled in espera)
chaves  in  4  player buttons, expected one-hot
mem_we  out  1  memory write enable, one cycle per stored move
mem_addr  out  ADDR_W  write address (= move counter)
mem_dado  out  4  write data (= latched chaves)
tamanho  out  ADDR_W+1  number of moves stored in the current/last recording
gravando  out  1  high in every state except inicial, fim, invalido
pronto  out  1  one-cycle pulse in fim
erro  out  1  one-cycle pulse in invalido
timeout  out  1  one-cycle pulse on timeout (0 when feature compiled out)
db_estado  out  4  current state code

Behaviour:
- Reset is asynchronous: state inicial, counter 0, data register 0, tamanho 0. All pulses are 0 and db_estado = 0.
- States and codes: inicial 0, preparacao 1, espera 2, solta 3, registra 4, grava 5, proximo 6, fim D, invalido E. Any other code shows db_estado = F and goes to inicial.
- inicial: iniciar=1 -> preparacao, else stay. tamanho holds the last result.
- preparacao: clear counter, data register and tamanho -> solta.
- solta: wait until chaves == 0, then -> espera. This blocks a held button from being recorded twice.
- espera: priority is finalizar, then key.
  - finalizar=1 -> fim.
  - chaves is exactly one-hot -> registra.
  - chaves is nonzero and not one-hot -> invalido.
  - chaves == 0 -> stay.
- registra: data register <= chaves -> grava.
- grava: mem_we=1 for exactly this cycle, with mem_addr = counter and mem_dado = register. tamanho <= counter+1.
  - If counter == N-1 -> fim.
  - Otherwise -> proximo.
- proximo: counter++ -> solta.
- fim: pronto=1 -> inicial.
- invalido: erro=1 -> inicial. Memory words already written stay valid. tamanho keeps the count of valid moves.
- Latency: a valid press is written 2 cycles after it is first sampled in espera (espera -> registra -> grava).
- Output rules: mem_addr and mem_dado always reflect the counter and register. mem_we is 0 outside grava.
- finalizar asserted at the same moment as a key: finalizar wins and the key is not stored.
- Counter never wraps. At N stored moves the block ends in fim.
- finalizar with 0 moves: fim with tamanho = 0 and no writes.
- Reset mid-operation aborts immediately. A write in progress is dropped (mem_we goes to 0 asynchronously).

Optional Feature:
GRAVADOR_TIMEOUT_EN:
- Defined:
  - An idle counter clears on every entry into espera and increments each cycle the block remains in espera.
  - When it reaches TIMEOUT_CICLOS with no key and no finalizar: -> invalido, asserting timeout=1 and erro=1 together for one cycle.
- Not defined: timeout is tied to 0 and espera waits indefinitely.

Test Plan:
- Reset, iniciar=1, press 0001, 0010, 0100, then finalizar -> writes (0,0001), (1,0010), (2,0100), each mem_we one cycle wide; pronto pulses; tamanho=3; db_estado returns to 0.
- Hold 1000 for 10 cycles, release, press 1000 again -> exactly 2 writes at addr 0 and 1, both 1000.
- Press 16 valid keys with N=16 -> last write at addr 15; pronto with no finalizar; tamanho=16; no 17th write.
- After 2 valid keys, press 0011 -> erro pulses with no write; tamanho=2; state returns to inicial.
- finalizar and 0100 in the same cycle in espera -> fim with no write; also check iniciar then immediate finalizar gives tamanho=0.
- Assert reset during grava -> mem_we drops the same cycle and all outputs return to reset values. With GRAVADOR_TIMEOUT_EN and TIMEOUT_CICLOS=20, idle for 20 cycles -> timeout and erro pulse.
